expt_ctrl: RTL and testbench

EXPT_CTRL -- requirements
Module: expt_ctrl

---
 rtl/expt_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_expt_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expt_ctrl.sv
// -----------------------------------------------------------------------------
// expt_ctrl -- exception / interrupt controller with a free-running timer.
//
// Takes synchronous exceptions, syscall and level-sensitive interrupts. For
// each taken event it issues a one-cycle flush/redirect pulse and saves the
// return PC and the cause code. A return-from-handler request redirects back
// to the saved PC. A 32-bit counter with a compare register raises a sticky
// timer interrupt.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   exp_valid_i         pipeline reports an exception this cycle
//   exp_no_i   [7:0]    exception number
//   exp_pc_i   [A-1:0]  PC of the faulting / interrupted instruction
//   eret_i              return-from-handler request
//   int_i      [N-1:0]  external interrupt lines (level)
//   mask_we_i, mask_i   mask write; bit NUM_INT masks the timer
//   cmp_we_i, cmp_i     timer compare write (also clears the timer interrupt)
//   exp_pc_o            redirect target, valid while flush_o=1
//   flush_o             one-cycle flush / redirect pulse
//   epc_o               saved return PC
//   cause_o             code of the last event taken
//   in_exc_o            handler active
//   timer_int_o         timer interrupt pending (sticky)
//   count_o             free-running counter
// -----------------------------------------------------------------------------
module expt_ctrl #(
  parameter int                NUM_INT = 6,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] VEC_EXC = ADDR_W'(32'h20),
  parameter logic [ADDR_W-1:0] VEC_INT = ADDR_W'(32'h40)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid_i,
  input  logic [7:0]        exp_no_i,
  input  logic [ADDR_W-1:0] exp_pc_i,
  input  logic              eret_i,
  input  logic [NUM_INT-1:0] int_i,
  input  logic              mask_we_i,
  input  logic [NUM_INT:0]  mask_i,
  input  logic              cmp_we_i,
  input  logic [31:0]       cmp_i,
  output logic [ADDR_W-1:0] exp_pc_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic [7:0]        cause_o,
  output logic              in_exc_o,
  output logic              timer_int_o,
  output logic [31:0]       count_o
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER, S_RET} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   exp_pc_q, exp_pc_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic [7:0]          cause_q, cause_d;
  logic                flush_q, flush_d;
  logic                in_exc_q, in_exc_d;
  logic                timer_q, timer_d;
  logic [31:0]         count_q, count_d;
  logic [31:0]         cmp_q, cmp_d;
  logic [NUM_INT:0]    mask_q, mask_d;

  logic                legal_exc;
  logic [NUM_INT:0]    irq_req;
  logic                irq_valid;
  logic [7:0]          irq_code;
  logic                timer_match;

  // Codes outside 0..19 and 80 are dropped as if exp_valid_i were low.
  assign legal_exc = exp_valid_i && ((exp_no_i <= 8'd19) || (exp_no_i == 8'd80));

  // Interrupt arbitration; the timer sits at index NUM_INT, so it has the
  // lowest priority. Walking downwards leaves the lowest active index in place.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    irq_req  = {timer_q & ~mask_q[NUM_INT], int_i & ~mask_q[NUM_INT-1:0]};
    irq_valid = |irq_req;
    irq_code = 8'd0;
    for (int i = NUM_INT; i >= 0; i--) begin
      if (irq_req[i]) irq_code = 8'(32 + i);
    end
  end

  // Next-state logic. A nested exception re-enters TAKE so that the flush
  // pulse is followed by a flush-free cycle before HANDLER again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (legal_exc || irq_valid) state_d = S_TAKE;
      S_TAKE:    state_d = S_HANDLER;
      S_HANDLER: begin
        if (legal_exc)   state_d = S_TAKE;
        else if (eret_i) state_d = S_RET;
      end
      S_RET:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next-values; all outputs come straight from registers.
  always_comb begin
    flush_d  = 1'b0;
    exp_pc_d = exp_pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (legal_exc) begin
          flush_d  = 1'b1;
          epc_d    = exp_pc_i;
          cause_d  = exp_no_i;
          exp_pc_d = (exp_no_i == 8'd80) ? VEC_INT : VEC_EXC;
        end else if (irq_valid) begin
          flush_d  = 1'b1;
          epc_d    = exp_pc_i;
          cause_d  = irq_code;
          exp_pc_d = VEC_INT;
        end
      end
      S_HANDLER: begin
        // Nested exception keeps the original return PC.
        if (legal_exc) begin
          flush_d  = 1'b1;
          cause_d  = exp_no_i;
          exp_pc_d = VEC_EXC;
        end else if (eret_i) begin
          flush_d  = 1'b1;
          exp_pc_d = epc_q;
        end
      end
      default: ;
    endcase
    in_exc_d = (state_d != S_IDLE);
  end

  // Timer: a compare write wins over a simultaneous match, suppressing both
  // the set and the reload. A compare of zero disables matching.
  always_comb begin
    timer_match = (cmp_q != 32'd0) && (count_q == cmp_q);
    count_d     = count_q + 32'd1;
    cmp_d       = cmp_q;
    timer_d     = timer_q;
    if (cmp_we_i) begin
      cmp_d   = cmp_i;
      timer_d = 1'b0;
    end else if (timer_match) begin
      timer_d = 1'b1;
      count_d = 32'd0;
    end
    mask_d = mask_we_i ? mask_i : mask_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      exp_pc_q <= '0;
      epc_q    <= '0;
      cause_q  <= 8'd0;
      flush_q  <= 1'b0;
      in_exc_q <= 1'b0;
      timer_q  <= 1'b0;
      count_q  <= 32'd0;
      cmp_q    <= 32'hFFFF_FFFF;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      exp_pc_q <= exp_pc_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      flush_q  <= flush_d;
      in_exc_q <= in_exc_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      mask_q   <= mask_d;
    end
  end

  assign exp_pc_o    = exp_pc_q;
  assign flush_o     = flush_q;
  assign epc_o       = epc_q;
  assign cause_o     = cause_q;
  assign in_exc_o    = in_exc_q;
  assign timer_int_o = timer_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_expt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_expt_ctrl -- self-checking bench for expt_ctrl.
// Directed scenarios check the documented examples with constants; a random
// phase compares every output each cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_expt_ctrl;

  localparam int NUM_INT = 6;
  localparam int ADDR_W  = 32;
  localparam int VW      = 2 * ADDR_W + 43;

  logic               clk = 1'b0;
  logic               rst;
  logic               exp_valid;
  logic [7:0]         exp_no;
  logic [ADDR_W-1:0]  exp_pc;
  logic               eret;
  logic [NUM_INT-1:0] int_l;
  logic               mask_we;
  logic [NUM_INT:0]   mask_d;
  logic               cmp_we;
  logic [31:0]        cmp_d;
  logic [ADDR_W-1:0]  exp_pc_o;
  logic               flush_o;
  logic [ADDR_W-1:0]  epc_o;
  logic [7:0]         cause_o;
  logic               in_exc_o;
  logic               timer_int_o;
  logic [31:0]        count_o;

  int n_checks = 0;
  int n_errors = 0;

  expt_ctrl #(.NUM_INT(NUM_INT), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .exp_valid_i (exp_valid),
    .exp_no_i    (exp_no),
    .exp_pc_i    (exp_pc),
    .eret_i      (eret),
    .int_i       (int_l),
    .mask_we_i   (mask_we),
    .mask_i      (mask_d),
    .cmp_we_i    (cmp_we),
    .cmp_i       (cmp_d),
    .exp_pc_o    (exp_pc_o),
    .flush_o     (flush_o),
    .epc_o       (epc_o),
    .cause_o     (cause_o),
    .in_exc_o    (in_exc_o),
    .timer_int_o (timer_int_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {exp_pc_o, flush_o, epc_o, cause_o, in_exc_o, timer_int_o, count_o};

  // ---------------- behavioural reference model ----------------
  typedef enum {P_IDLE, P_TAKE, P_HND, P_RET} phase_e;
  phase_e            m_phase;
  logic [ADDR_W-1:0] m_exp_pc, m_epc;
  logic [7:0]        m_cause;
  logic              m_flush, m_in_exc, m_timer;
  logic [31:0]       m_count, m_cmp;
  logic [NUM_INT:0]  m_mask;

  function automatic logic [VW-1:0] model_vec();
    return {m_exp_pc, m_flush, m_epc, m_cause, m_in_exc, m_timer, m_count};
  endfunction

  // Advances the model by one rising edge using the inputs present at it.
  task automatic model_step();
    logic   legal;
    int     irq;
    phase_e n_phase;
    if (rst) begin
      m_phase = P_IDLE; m_exp_pc = '0; m_epc = '0; m_cause = 0;
      m_flush = 0; m_in_exc = 0; m_timer = 0; m_count = 0;
      m_cmp = 32'hFFFF_FFFF; m_mask = '1;
      return;
    end
    legal = exp_valid && (exp_no <= 19 || exp_no == 80);
    irq = -1;
    for (int i = 0; i <= NUM_INT; i++) begin
      logic r;
      r = (i == NUM_INT) ? (m_timer && !m_mask[i]) : (int_l[i] && !m_mask[i]);
      if (r && irq < 0) irq = 32 + i;
    end
    n_phase = m_phase;
    m_flush = 0;
    if (m_phase == P_IDLE) begin
      if (legal) begin
        m_flush = 1; m_epc = exp_pc; m_cause = exp_no;
        m_exp_pc = (exp_no == 80) ? 'h40 : 'h20;
        n_phase = P_TAKE;
      end else if (irq >= 0) begin
        m_flush = 1; m_epc = exp_pc; m_cause = 8'(irq); m_exp_pc = 'h40;
        n_phase = P_TAKE;
      end
    end else if (m_phase == P_TAKE) begin
      n_phase = P_HND;
    end else if (m_phase == P_HND) begin
      if (legal) begin
        m_flush = 1; m_cause = exp_no; m_exp_pc = 'h20; n_phase = P_TAKE;
      end else if (eret) begin
        m_flush = 1; m_exp_pc = m_epc; n_phase = P_RET;
      end
    end else begin
      n_phase = P_IDLE;
    end
    m_phase  = n_phase;
    m_in_exc = (n_phase != P_IDLE);
    if (cmp_we) begin
      m_cmp = cmp_d; m_timer = 0; m_count = m_count + 1;
    end else if (m_cmp != 0 && m_count == m_cmp) begin
      m_timer = 1; m_count = 0;
    end else begin
      m_count = m_count + 1;
    end
    if (mask_we) m_mask = mask_d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Assumes the FSM has just entered TAKE; walks it back to IDLE.
  task automatic return_to_idle();
    tick();
    eret = 1; tick(); eret = 0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; tick(); tick();
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    rst = 0; tick();
    n_checks++;
    if (count_o !== 32'd1) begin
      n_errors++; $display("FAIL count_after_reset: got %0d want 1", count_o);
    end
  endtask

  task automatic test_exception();
    exp_valid = 1; exp_no = 5; exp_pc = 'h100; tick(); exp_valid = 0;
    n_checks++;
    if ({flush_o, exp_pc_o, epc_o, cause_o, in_exc_o} !== {1'b1, 32'h20, 32'h100, 8'd5, 1'b1}) begin
      n_errors++;
      $display("FAIL exc_take: got flush=%b pc=%h epc=%h cause=%0d in_exc=%b want 1 20 100 5 1",
               flush_o, exp_pc_o, epc_o, cause_o, in_exc_o);
    end
    tick();
    n_checks++;
    if ({flush_o, in_exc_o} !== 2'b01) begin
      n_errors++; $display("FAIL exc_after: got flush=%b in_exc=%b want 0 1", flush_o, in_exc_o);
    end
  endtask

  task automatic test_handler_exc();
    exp_valid = 1; exp_no = 12; exp_pc = 'h200; tick(); exp_valid = 0;
    n_checks++;
    if ({flush_o, exp_pc_o, cause_o, epc_o} !== {1'b1, 32'h20, 8'd12, 32'h100}) begin
      n_errors++;
      $display("FAIL nested_exc: got flush=%b pc=%h cause=%0d epc=%h want 1 20 12 100",
               flush_o, exp_pc_o, cause_o, epc_o);
    end
    tick();
    mask_we = 1; mask_d = '0; int_l = 6'b000001; tick(); mask_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (flush_o !== 1'b0) begin
        n_errors++; $display("FAIL int_in_handler: got flush=%b want 0", flush_o);
      end
    end
  endtask

  task automatic test_eret();
    int_l = '0; eret = 1; tick(); eret = 0;
    n_checks++;
    if ({flush_o, exp_pc_o, in_exc_o} !== {1'b1, 32'h100, 1'b1}) begin
      n_errors++;
      $display("FAIL eret: got flush=%b pc=%h in_exc=%b want 1 100 1", flush_o, exp_pc_o, in_exc_o);
    end
    tick();
    n_checks++;
    if ({flush_o, in_exc_o} !== 2'b00) begin
      n_errors++; $display("FAIL eret_idle: got flush=%b in_exc=%b want 0 0", flush_o, in_exc_o);
    end
  endtask

  task automatic test_interrupt();
    int_l = 6'b000110; exp_pc = 'h300; tick(); int_l = '0;
    n_checks++;
    if ({flush_o, cause_o, exp_pc_o, epc_o} !== {1'b1, 8'd33, 32'h40, 32'h300}) begin
      n_errors++;
      $display("FAIL irq_take: got flush=%b cause=%0d pc=%h epc=%h want 1 33 40 300",
               flush_o, cause_o, exp_pc_o, epc_o);
    end
    return_to_idle();
    // Exception beats a simultaneous interrupt; the interrupt stays pending.
    int_l = 6'b000110; exp_valid = 1; exp_no = 7; exp_pc = 'h340; tick(); exp_valid = 0;
    n_checks++;
    if ({cause_o, exp_pc_o, epc_o} !== {8'd7, 32'h20, 32'h340}) begin
      n_errors++;
      $display("FAIL exc_over_irq: got cause=%0d pc=%h epc=%h want 7 20 340", cause_o, exp_pc_o, epc_o);
    end
    return_to_idle();
    tick();
    n_checks++;
    if ({flush_o, cause_o} !== {1'b1, 8'd33}) begin
      n_errors++; $display("FAIL irq_pending: got flush=%b cause=%0d want 1 33", flush_o, cause_o);
    end
    int_l = '0;
    return_to_idle();
    exp_valid = 1; exp_no = 80; exp_pc = 'h380; tick(); exp_valid = 0;
    n_checks++;
    if ({cause_o, exp_pc_o} !== {8'd80, 32'h40}) begin
      n_errors++; $display("FAIL syscall: got cause=%0d pc=%h want 80 40", cause_o, exp_pc_o);
    end
    return_to_idle();
  endtask

  task automatic test_timer();
    rst = 1; tick(); rst = 0;
    cmp_we = 1; cmp_d = 3; mask_we = 1; mask_d = '0; tick(); cmp_we = 0; mask_we = 0;
    for (int i = 0; i < 10 && !timer_int_o; i++) tick();
    n_checks++;
    if ({timer_int_o, count_o} !== {1'b1, 32'd0}) begin
      n_errors++; $display("FAIL timer_fire: got timer=%b count=%0d want 1 0", timer_int_o, count_o);
    end
    tick();
    n_checks++;
    if ({flush_o, cause_o, exp_pc_o, timer_int_o} !== {1'b1, 8'(32 + NUM_INT), 32'h40, 1'b1}) begin
      n_errors++;
      $display("FAIL timer_take: got flush=%b cause=%0d pc=%h timer=%b want 1 %0d 40 1",
               flush_o, cause_o, exp_pc_o, timer_int_o, 32 + NUM_INT);
    end
    cmp_we = 1; cmp_d = 0; tick(); cmp_we = 0;
    n_checks++;
    if (timer_int_o !== 1'b0) begin
      n_errors++; $display("FAIL timer_clear: got timer=%b want 0", timer_int_o);
    end
    eret = 1; tick(); eret = 0; tick();
  endtask

  task automatic test_reset_mid();
    exp_valid = 1; exp_no = 3; exp_pc = 'h500; tick(); exp_valid = 0; tick();
    rst = 1; tick(); rst = 0;
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++; $display("FAIL reset_mid: got %h want 0", dut_vec);
    end
    exp_valid = 1; exp_no = 25; tick(); exp_valid = 0;
    n_checks++;
    if ({flush_o, in_exc_o, cause_o} !== {1'b0, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL illegal_code: got flush=%b in_exc=%b cause=%0d want 0 0 0", flush_o, in_exc_o, cause_o);
    end
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 199) == 0);
      exp_valid = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: exp_no = 8'($urandom_range(0, 19));
        3:       exp_no = 8'd80;
        4:       exp_no = 8'($urandom_range(20, 79));
        default: exp_no = 8'($urandom_range(81, 255));
      endcase
      exp_pc  = $urandom;
      eret    = ($urandom_range(0, 5) == 0);
      int_l   = ($urandom_range(0, 3) == 0) ? NUM_INT'($urandom) : '0;
      mask_we = ($urandom_range(0, 19) == 0);
      mask_d  = (NUM_INT + 1)'($urandom);
      cmp_we  = ($urandom_range(0, 29) == 0);
      cmp_d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 60))
                                            : m_count + 32'($urandom_range(1, 20));
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec, model_vec());
      end
    end
    rst = 0; exp_valid = 0; eret = 0; int_l = '0; mask_we = 0; cmp_we = 0;
  endtask

  initial begin
    rst = 1; exp_valid = 0; exp_no = 0; exp_pc = '0; eret = 0; int_l = '0;
    mask_we = 0; mask_d = '0; cmp_we = 0; cmp_d = 0;
    test_reset();
    test_exception();
    test_handler_exc();
    test_eret();
    test_interrupt();
    test_timer();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
